// File: rtl/l2_irefill_if.sv
`default_nettype none
// ============================================================================
//  Module   : l2_irefill_if
//  Brief    : Icache refill and memory word-read bus bundle for l2_irefill.
//  Revision : 1.0  initial release
// ============================================================================
interface l2_irefill_if;
    // icache side
    logic           ic_req;
    logic [31:0]    ic_req_addr;
    logic           inval;
    logic [255:0]   L2_block_read;
    logic [31:0]    L2_addr_read;
    logic           L2_stall;
    logic           l2_valid;
    // memory side
    logic           mem_req;
    logic [31:0]    mem_addr;
    logic           mem_gnt;
    logic           mem_rvalid;
    logic [31:0]    mem_rdata;

    // slave: the refill responder itself
    modport slave (
        input  ic_req, ic_req_addr, inval, mem_gnt, mem_rvalid, mem_rdata,
        output L2_block_read, L2_addr_read, L2_stall, l2_valid, mem_req, mem_addr
    );

    // master: the icache plus memory arbiter environment
    modport master (
        output ic_req, ic_req_addr, inval, mem_gnt, mem_rvalid, mem_rdata,
        input  L2_block_read, L2_addr_read, L2_stall, l2_valid, mem_req, mem_addr
    );
endinterface
`default_nettype wire

// File: rtl/l2_irefill.sv
`default_nettype none
// ============================================================================
//  Module   : l2_irefill
//  Brief    : L2-side icache refill responder with a one-line buffer and an
//             eight-word pipelined memory fill.
//  Revision : 1.0  initial release
// ============================================================================
module l2_irefill #(
    parameter int OUTSTANDING = 8
) (
    input  wire logic   clk,
    input  wire logic   rst,
    l2_irefill_if.slave bus
);

    localparam logic [3:0] c_MAX_OUT = 4'(OUTSTANDING);
    localparam logic [3:0] c_WORDS   = 4'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         r_state;
    logic           r_buf_valid;
    logic [26:0]    r_buf_addr;
    logic [26:0]    r_line;
    logic [3:0]     r_issued;
    logic [3:0]     r_recv;
    logic           r_inval_seen;
    logic [255:0]   r_fill;

    logic           w_issue;
    logic           w_accept;
    logic           w_hit;
    logic [3:0]     w_issued_nxt;
    logic [3:0]     w_recv_nxt;
    logic [3:0]     w_inflight_nxt;
    logic [255:0]   w_fill;

    always_comb begin
        w_issue        = bus.mem_req & bus.mem_gnt;
        // responses with nothing in flight are protocol errors and dropped
        w_accept       = (r_state == FILL) && bus.mem_rvalid &&
                         (r_recv != r_issued) && (r_recv != c_WORDS);
        w_issued_nxt   = r_issued + {3'b000, w_issue};
        w_recv_nxt     = r_recv + {3'b000, w_accept};
        w_inflight_nxt = w_issued_nxt - w_recv_nxt;
        w_hit          = r_buf_valid && !bus.inval &&
                         (bus.ic_req_addr[31:5] == r_buf_addr);
        w_fill         = r_fill;
        if (w_accept) begin
            w_fill[{r_recv[2:0], 5'b00000} +: 32] = bus.mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= IDLE;
            r_buf_valid       <= 1'b0;
            r_buf_addr        <= '0;
            r_line            <= '0;
            r_issued          <= '0;
            r_recv            <= '0;
            r_inval_seen      <= 1'b0;
            r_fill            <= '0;
            bus.L2_block_read <= '0;
            bus.L2_addr_read  <= '0;
            bus.L2_stall      <= 1'b0;
            bus.l2_valid      <= 1'b0;
            bus.mem_req       <= 1'b0;
            bus.mem_addr      <= '0;
        end else begin
            if (bus.inval) begin
                r_buf_valid <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (bus.ic_req) begin
                        if (w_hit) begin
                            r_state      <= DONE;
                            bus.l2_valid <= 1'b1;
                        end else begin
                            r_state      <= FILL;
                            r_line       <= bus.ic_req_addr[31:5];
                            r_buf_valid  <= 1'b0;
                            r_issued     <= '0;
                            r_recv       <= '0;
                            r_inval_seen <= 1'b0;
                            bus.L2_stall <= 1'b1;
                            bus.mem_req  <= 1'b1;
                            bus.mem_addr <= {bus.ic_req_addr[31:5], 5'b00000};
                        end
                    end
                end
                FILL: begin
                    r_issued <= w_issued_nxt;
                    r_recv   <= w_recv_nxt;
                    r_fill   <= w_fill;
                    if (bus.inval) begin
                        r_inval_seen <= 1'b1;
                    end
                    if (w_recv_nxt == c_WORDS) begin
                        r_state           <= DONE;
                        bus.l2_valid      <= 1'b1;
                        bus.L2_stall      <= 1'b0;
                        bus.mem_req       <= 1'b0;
                        bus.L2_block_read <= w_fill;
                        bus.L2_addr_read  <= {r_line, 5'b00000};
                        r_buf_addr        <= r_line;
                        // a fence.i seen at any point of the fill leaves the line unusable
                        r_buf_valid       <= !(r_inval_seen | bus.inval);
                    end else begin
                        bus.mem_req  <= (w_issued_nxt < c_WORDS) &&
                                        (w_inflight_nxt < c_MAX_OUT);
                        bus.mem_addr <= {r_line, w_issued_nxt[2:0], 2'b00};
                    end
                end
                DONE: begin
                    bus.l2_valid <= 1'b0;
                    r_state      <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_l2_irefill.sv
`default_nettype none
// ============================================================================
//  Module   : tb_l2_irefill
//  Brief    : Self-checking bench for l2_irefill with a pipelined memory model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_l2_irefill;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    l2_irefill_if b1 ();
    l2_irefill_if b2 ();

    l2_irefill #(.OUTSTANDING(8)) u_dut8 (.clk(clk), .rst(rst), .bus(b1));
    l2_irefill #(.OUTSTANDING(2)) u_dut2 (.clk(clk), .rst(rst), .bus(b2));

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    typedef struct {
        logic [31:0] addr;
        bit          inv_same;
        int          inv_mid;
        int          lat;
        int          gmode;
        logic [31:0] base;
        int          exp_lat;
        int          exp_nreq;
        bit          exp_stall;
        logic [31:0] exp_addr;
        logic [31:0] exp_base;
    } vec_t;

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          lat_cfg = 1;
    int          gnt_mode = 0;
    int          t_cyc = 0;
    logic [31:0] data_base = 32'h0;
    int          n_grant = 0;
    int          n_pop = 0;
    int          max_out = 0;
    int          ord_err = 0;
    int          stab_err = 0;
    int          exp_idx = 0;
    logic [26:0] exp_line = '0;
    pend_t       q[$];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] blk(input logic [31:0] b);
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[32*k +: 32] = b + 32'(k);
        return r;
    endfunction

    // Memory model: grants queue responses that return lat_cfg cycles later, in order.
    initial begin : g_mem_model
        logic        w_req;
        logic [31:0] wa;
        logic        prev_wait;
        logic [31:0] prev_addr;
        pend_t       p;
        logic        rv;
        prev_wait = 1'b0;
        prev_addr = '0;
        b1.mem_gnt = 1'b0; b1.mem_rvalid = 1'b0; b1.mem_rdata = '0;
        b2.mem_gnt = 1'b0; b2.mem_rvalid = 1'b0; b2.mem_rdata = '0;
        forever begin
            @(posedge clk);
            cyc++;
            w_req = b1.mem_req | b2.mem_req;
            wa    = b1.mem_req ? b1.mem_addr : b2.mem_addr;
            if (rst) begin
                q.delete();
                prev_wait = 1'b0;
            end else begin
                if (b1.mem_rvalid && q.size() > 0) begin
                    void'(q.pop_front());
                    n_pop++;
                end
                if (w_req && b1.mem_gnt) begin
                    if (exp_idx >= 8 || wa != {exp_line, exp_idx[2:0], 2'b00}) ord_err++;
                    exp_idx++;
                    p.addr = wa;
                    p.due  = cyc + lat_cfg;
                    q.push_back(p);
                    n_grant++;
                end
                if (w_req && prev_wait && wa != prev_addr) stab_err++;
                prev_wait = w_req && !b1.mem_gnt;
                prev_addr = wa;
                if (q.size() > max_out) max_out = q.size();
            end
            @(negedge clk);
            rv = (q.size() > 0) && (q[0].due <= cyc + 1);
            b1.mem_gnt    = (gnt_mode == 0) ? 1'b1 : (((cyc + 1 - t_cyc) % 2) == 0);
            b2.mem_gnt    = b1.mem_gnt;
            b1.mem_rvalid = rv;
            b2.mem_rvalid = rv;
            b1.mem_rdata  = rv ? data_base + {29'b0, q[0].addr[4:2]} : 32'h0;
            b2.mem_rdata  = b1.mem_rdata;
        end
    end

    task automatic drive_ic(input bit u, input logic req, input logic [31:0] a, input logic inv);
        if (u) begin
            b2.ic_req = req; b2.ic_req_addr = a; b2.inval = inv;
        end else begin
            b1.ic_req = req; b1.ic_req_addr = a; b1.inval = inv;
        end
    endtask

    function automatic logic o_valid(input bit u);
        return u ? b2.l2_valid : b1.l2_valid;
    endfunction
    function automatic logic o_stall(input bit u);
        return u ? b2.L2_stall : b1.L2_stall;
    endfunction
    function automatic logic o_req(input bit u);
        return u ? b2.mem_req : b1.mem_req;
    endfunction
    function automatic logic [255:0] o_blk(input bit u);
        return u ? b2.L2_block_read : b1.L2_block_read;
    endfunction
    function automatic logic [31:0] o_addr(input bit u);
        return u ? b2.L2_addr_read : b1.L2_addr_read;
    endfunction

    // Issues one request and follows it to l2_valid; lat is cycles from the sampling edge.
    task automatic run_req(input bit u, input logic [31:0] addr, input bit inv_same, input int inv_mid,
                           output int lat, output bit st_first, output bit st_any,
                           output bit st_at_valid, output bit req_low);
        int k;
        bit got;
        @(posedge clk); #1;
        exp_line = addr[31:5];
        exp_idx  = 0;
        ord_err  = 0;
        stab_err = 0;
        n_grant  = 0;
        max_out  = 0;
        t_cyc    = cyc + 1;
        drive_ic(u, 1'b1, addr, inv_same);
        @(posedge clk); #1;
        k = 1; got = 0; lat = 0; st_any = 0; st_at_valid = 0; req_low = 0;
        st_first = o_stall(u);
        while (!got && k < 200) begin
            if (o_stall(u)) st_any = 1;
            if (o_valid(u)) begin
                got = 1;
                lat = k;
                st_at_valid = o_stall(u);
            end else begin
                if (o_stall(u) && !o_req(u) && n_grant < 8) req_low = 1;
                drive_ic(u, 1'b1, addr, k == inv_mid);
                @(posedge clk); #1;
                k++;
            end
        end
        drive_ic(u, 1'b0, addr, 1'b0);
        if (!got) begin
            n_chk++;
            n_err++;
            $display("FAIL timeout: l2_valid not seen for addr %0h within %0d cycles", addr, k);
        end
    endtask

    vec_t vecs[9];

    initial begin : g_main
        int  lat;
        bit  st_first, st_any, st_at_valid, req_low;
        string nm;
        vecs[0] = '{32'h0000_1044, 0, 0, 1, 0, 32'hA000_0000, 10, 8, 1, 32'h0000_1040, 32'hA000_0000};
        vecs[1] = '{32'h0000_105C, 0, 0, 1, 0, 32'h1111_1111,  1, 0, 0, 32'h0000_1040, 32'hA000_0000};
        vecs[2] = '{32'h0000_1040, 1, 0, 1, 0, 32'hB000_0000, 10, 8, 1, 32'h0000_1040, 32'hB000_0000};
        vecs[3] = '{32'h0000_1040, 0, 0, 1, 0, 32'h2222_2222,  1, 0, 0, 32'h0000_1040, 32'hB000_0000};
        vecs[4] = '{32'h0000_3000, 0, 0, 3, 0, 32'hC000_0000, 12, 8, 1, 32'h0000_3000, 32'hC000_0000};
        vecs[5] = '{32'h0000_4010, 0, 0, 1, 1, 32'hD000_0000, 18, 8, 1, 32'h0000_4000, 32'hD000_0000};
        vecs[6] = '{32'h0000_5000, 0, 4, 1, 0, 32'hE000_0000, 10, 8, 1, 32'h0000_5000, 32'hE000_0000};
        vecs[7] = '{32'h0000_5004, 0, 0, 1, 0, 32'hF000_0000, 10, 8, 1, 32'h0000_5000, 32'hF000_0000};
        vecs[8] = '{32'h0000_5008, 0, 0, 1, 0, 32'h3333_3333,  1, 0, 0, 32'h0000_5000, 32'hF000_0000};

        rst = 1'b1;
        drive_ic(0, 1'b0, 32'h0, 1'b0);
        drive_ic(1, 1'b0, 32'h0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_block", b1.L2_block_read, '0);
        chk("reset_addr", {224'b0, b1.L2_addr_read}, '0);
        chk("reset_stall", {255'b0, b1.L2_stall}, '0);
        chk("reset_valid", {255'b0, b1.l2_valid}, '0);
        chk("reset_mem_req", {255'b0, b1.mem_req}, '0);
        chk("reset_mem_addr", {224'b0, b1.mem_addr}, '0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            lat_cfg   = vecs[i].lat;
            gnt_mode  = vecs[i].gmode;
            data_base = vecs[i].base;
            run_req(0, vecs[i].addr, vecs[i].inv_same, vecs[i].inv_mid,
                    lat, st_first, st_any, st_at_valid, req_low);
            nm = $sformatf("v%0d", i);
            chk({nm, "_latency"}, 256'(lat), 256'(vecs[i].exp_lat));
            chk({nm, "_nreq"}, 256'(n_grant), 256'(vecs[i].exp_nreq));
            chk({nm, "_stall_first"}, {255'b0, st_first}, {255'b0, vecs[i].exp_stall});
            chk({nm, "_stall_any"}, {255'b0, st_any}, {255'b0, vecs[i].exp_stall});
            chk({nm, "_stall_at_valid"}, {255'b0, st_at_valid}, '0);
            chk({nm, "_req_gap"}, {255'b0, req_low}, '0);
            chk({nm, "_addr_read"}, {224'b0, o_addr(0)}, {224'b0, vecs[i].exp_addr});
            chk({nm, "_block"}, o_blk(0), blk(vecs[i].exp_base));
            chk({nm, "_order"}, 256'(ord_err), '0);
            chk({nm, "_addr_stable"}, 256'(stab_err), '0);
        end

        // Two outstanding, data latency 5: the request line must throttle.
        lat_cfg = 5; gnt_mode = 0; data_base = 32'h6000_0000;
        run_req(1, 32'h0000_6008, 0, 0, lat, st_first, st_any, st_at_valid, req_low);
        chk("out2_latency", 256'(lat), 256'(26));
        chk("out2_max_outstanding", 256'(max_out), 256'(2));
        chk("out2_req_dropped", {255'b0, req_low}, {255'b0, 1'b1});
        chk("out2_nreq", 256'(n_grant), 256'(8));
        chk("out2_order", 256'(ord_err), '0);
        chk("out2_addr_read", {224'b0, o_addr(1)}, {224'b0, 32'h0000_6000});
        chk("out2_block", o_blk(1), blk(32'h6000_0000));

        // Reset at the fourth returned word, then a fresh fill.
        lat_cfg = 1; gnt_mode = 0; data_base = 32'h7000_0000;
        @(posedge clk); #1;
        exp_line = 27'(32'h0000_7000 >> 5);
        exp_idx = 0;
        n_pop = 0;
        drive_ic(0, 1'b1, 32'h0000_7000, 1'b0);
        for (int k = 0; k < 50 && n_pop < 4; k++) begin
            @(posedge clk); #1;
        end
        chk("mid_fill_words_returned", 256'(n_pop), 256'(4));
        rst = 1'b1;
        drive_ic(0, 1'b0, 32'h0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_block", b1.L2_block_read, '0);
        chk("rst_addr", {224'b0, b1.L2_addr_read}, '0);
        chk("rst_stall", {255'b0, b1.L2_stall}, '0);
        chk("rst_valid", {255'b0, b1.l2_valid}, '0);
        chk("rst_mem_req", {255'b0, b1.mem_req}, '0);
        chk("rst_mem_addr", {224'b0, b1.mem_addr}, '0);

        data_base = 32'h2000_0000;
        run_req(0, 32'h0000_2000, 0, 0, lat, st_first, st_any, st_at_valid, req_low);
        chk("refill_latency", 256'(lat), 256'(10));
        chk("refill_nreq", 256'(n_grant), 256'(8));
        chk("refill_order", 256'(ord_err), '0);
        chk("refill_addr_read", {224'b0, o_addr(0)}, {224'b0, 32'h0000_2000});
        chk("refill_block", o_blk(0), blk(32'h2000_0000));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin : g_watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/l2_irefill.md
# l2_irefill

L2-side refill responder for the L1 instruction cache: the producer end of the `L2_block_read` / `L2_addr_read` / `L2_stall` interface that the fetch stage's icache consumes.
- On an icache miss request it returns a 256-bit, 32-byte-aligned block, either from a one-entry line buffer or by streaming eight 32-bit words from backing memory over a pipelined request/response bus.
- It sits between the icache and the memory arbiter.

## Interface
- `OUTSTANDING`, 8: maximum memory words requested but not yet returned; legal range 1..8.
- `clk`  in  1  clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `ic_req`  in  1  icache miss request; held high by the icache until `l2_valid`.
- `ic_req_addr`  in  32  miss address; bits [4:0] ignored.
- `inval`  in  1  one-cycle pulse; invalidates the line buffer (fence.i).
- `L2_block_read`  out  256  returned block; word k (byte offset 4k) in bits [32k+31:32k].
- `L2_addr_read`  out  32  block address of `L2_block_read`; bits [4:0] always 0.
- `L2_stall`  out  1  high while a miss fill is in progress.
- `l2_valid`  out  1  one-cycle pulse: `L2_block_read` / `L2_addr_read` are valid for the current request.
- `mem_req`  out  1  word read request.
- `mem_addr`  out  32  word address for `mem_req`; bits [1:0] = 0.
- `mem_gnt`  in  1  request accepted this cycle when `mem_req` is also high.
- `mem_rvalid`  in  1  read data valid; returns in request order, at least 1 cycle after its grant.
- `mem_rdata`  in  32  read data.

## Operation
- States: IDLE, FILL, DONE.
- Line buffer holds `buf_valid` and `buf_addr[31:5]`. `L2_block_read` and `L2_addr_read` are the buffer contents and hold their value between responses.
- IDLE:
  - If `inval`, clear `buf_valid`. `inval` takes priority over a same-cycle hit check.
  - On `ic_req` with a hit (`buf_valid` and `ic_req_addr[31:5]==buf_addr`, evaluated after `inval`), go to DONE. No memory traffic.
  - On `ic_req` with a miss, latch `ic_req_addr[31:5]`, clear `buf_valid`, reset the issue counter and receive counter (4-bit each), and go to FILL.
- FILL:
  - `mem_req` is high while issued<8 and (issued−received)<`OUTSTANDING`.
  - `mem_addr` = {latched[31:5], issued[2:0], 2'b00}, so words are issued 0..7 in ascending order.
  - The issue counter increments on `mem_req & mem_gnt`.
  - On each `mem_rvalid`, `mem_rdata` is written into block word `received[2:0]` and the receive counter increments.
  - `mem_rvalid` with received==issued, or with received==8, is a protocol error and is ignored.
  - When the 8th word is received, go to DONE. If no `inval` was seen during the fill, set `buf_valid`, `buf_addr`=latched.
  - An `inval` during FILL leaves `buf_valid` clear after the fill; the block is still delivered once.
- DONE: `l2_valid`=1 for exactly one cycle, then return to IDLE. `ic_req` is not sampled in DONE.
- `ic_req` in FILL/DONE is not re-evaluated. The requester holds it; a new request is taken only after returning to IDLE. The icache must drop `ic_req` the cycle after `l2_valid`.
- A mid-operation `rst` abandons the fill and discards in-flight responses. The memory side is reset by the same `rst`.

## Timing
- All outputs are registered.
- Reset values: `L2_block_read`=0, `L2_addr_read`=0, `L2_stall`=0, `l2_valid`=0, `mem_req`=0, `mem_addr`=0; `buf_valid`=0; state IDLE.
- Hit: `ic_req` sampled at cycle T → `l2_valid` at T+1. `L2_stall` stays 0.
- Miss:
  - `ic_req` sampled at T → `L2_stall`=1 and first `mem_req` at T+1.
  - Last `mem_rvalid` at R → at R+1 `l2_valid`=1, `L2_stall`=0, and the block/address are updated.
- Minimum miss latency with grant every cycle and 1-cycle data return: first grant T+1, last grant T+8, last data T+9, `l2_valid` T+10.
- `mem_gnt` and `mem_rvalid` in the same cycle are both processed.
- `mem_addr` is stable while `mem_req` is high and `mem_gnt` is low.

## Test plan
- Cold miss, `ic_req_addr`=0x0000_1044, memory returns word k = 0xA000_0000+k with 1-cycle latency → `mem_addr` 0x1040..0x105C in order, `l2_valid` at T+10, `L2_addr_read`=0x1040, `L2_block_read[31:0]`=0xA000_0000, `[255:224]`=0xA000_0007.
- Repeat request to 0x0000_105C after the previous test → `l2_valid` at T+1, no `mem_req`, `L2_stall` never high.
- `inval` in the same cycle as `ic_req`=0x1040 → treated as miss: 8 memory requests, `L2_stall` high from T+1.
- `OUTSTANDING`=2, `mem_gnt` always high, data latency 5 → never more than 2 requests ungranted-return, `mem_req` drops when the limit is reached, block correct.
- `inval` pulse during FILL → block delivered with `l2_valid`; a following request to the same address misses.
- `rst` asserted at the 4th received word, then a new `ic_req`=0x2000 → all outputs 0 the cycle after reset, and the fresh fill issues from 0x2000 with a correct block.
